// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, bus-owner encoding and default timing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   localparam int WAIT_STATES_DEF = 1;
   localparam int CNT_W           = 4;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between CPU and DMA requests.
// ROUND_ROBIN_EN: ties alternate away from the last owner; otherwise the CPU always wins a tie.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_cpu_req,
   input  logic   i_dma_req,
   input  owner_e i_last_owner,
   output logic   o_grant_valid,
   output owner_e o_grant_owner
);

`ifdef ROUND_ROBIN_EN
   always_comb begin
      o_grant_valid = i_cpu_req | i_dma_req;
      o_grant_owner = OWN_CPU;
      if (i_cpu_req && i_dma_req) begin
         o_grant_owner = other_owner(i_last_owner);
      end else if (i_dma_req) begin
         o_grant_owner = OWN_DMA;
      end
   end
`else
   logic w_unused_last_owner;

   // Fixed priority never looks at history.
   assign w_unused_last_owner = i_last_owner;

   always_comb begin
      o_grant_valid = i_cpu_req | i_dma_req;
      o_grant_owner = i_cpu_req ? OWN_CPU : OWN_DMA;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter: grants CPU or DMA one transaction at a time with fixed wait states.
// Tie-break policy selected by ROUND_ROBIN_EN (see arb_pick).
//
// state  | meaning
// IDLE   | arbitrate; latch winner and its wr/addr/wdata
// ACCESS | drive memory for WAIT_STATES cycles
// DONE   | one-cycle ack to the owner
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES = WAIT_STATES_DEF,
   parameter int AW          = 16,
   parameter int DW          = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_wr,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_oe,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WAIT_STATES - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   owner_e           r_owner;
   logic             r_wr;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic [CNT_W-1:0] r_cnt;
   logic [DW-1:0]    r_cpu_rdata;
   logic [DW-1:0]    r_dma_rdata;

   logic             w_grant_valid;
   owner_e           w_grant_owner;
   logic             w_grant;
   logic             w_last_beat;

   arb_pick u_arb_pick (
      .i_cpu_req     (cpu_req),
      .i_dma_req     (dma_req),
      .i_last_owner  (r_owner),
      .o_grant_valid (w_grant_valid),
      .o_grant_owner (w_grant_owner)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_last_beat = 1'b0;
      mem_wr      = 1'b0;
      mem_oe      = 1'b0;
      cpu_ack     = 1'b0;
      dma_ack     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_state_nxt = ACCESS;
               w_grant     = 1'b1;
            end
         end
         ACCESS: begin
            mem_wr = r_wr;
            mem_oe = r_wr;
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
               w_last_beat = 1'b1;
            end
         end
         DONE: begin
            cpu_ack     = (r_owner == OWN_CPU);
            dma_ack     = (r_owner == OWN_DMA);
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only at grant, so requesters may change inputs mid-access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner     <= OWN_DMA;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_grant_owner;
            r_cnt   <= LP_CNT_LOAD;
            if (w_grant_owner == OWN_CPU) begin
               r_wr    <= cpu_wr;
               r_addr  <= cpu_addr;
               r_wdata <= cpu_wdata;
            end else begin
               r_wr    <= dma_wr;
               r_addr  <= dma_addr;
               r_wdata <= dma_wdata;
            end
         end else if (r_state == ACCESS && r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_last_beat && !r_wr) begin
            if (r_owner == OWN_CPU) begin
               r_cpu_rdata <= mem_rdata;
            end else begin
               r_dma_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
